// File: rtl/uart_mem_loader.sv
// ============================================================================
// uart_mem_loader : 8N1 UART receiver that packs bytes little-endian into
//                   32-bit words and writes them to a RAM port.
// Revision 1.0
// ============================================================================
`default_nettype none

module uart_mem_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        serialIn,
    input  logic        setAddr,
    input  logic [11:0] startAddr,
    output logic [11:0] writeAddr,
    output logic [31:0] writeData,
    output logic        writeEnable,
    output logic        err,
    output logic [7:0]  lastByte
);
    localparam int CNT_W       = $clog2(CLKS_PER_BIT);
    localparam int IDLE_CYCLES = IDLE_TIMEOUT * CLKS_PER_BIT;
    localparam int IDLE_W      = $clog2(IDLE_CYCLES + 1);

    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic              sync1_q, sync2_q, rx_prev_q;
    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        bit_idx_q;
    logic [7:0]        shift_q;
    logic [1:0]        byte_cnt_q;
    logic [IDLE_W-1:0] idle_cnt_q;
    logic [11:0]       addr_q;
    logic [31:0]       data_q;
    logic              we_q, err_q;
    logic [7:0]        last_q;

    logic rx;
    logic cnt_clr, bit_sample, stop_sample;
    logic byte_ok, frame_err, word_done, idle_wait, timeout;

    assign rx = sync2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            sync1_q   <= serialIn;
            sync2_q   <= sync1_q;
            rx_prev_q <= sync2_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (rx_prev_q && !rx) state_d = S_START;
            S_START: if (cnt_q == HALF_LAST) state_d = rx ? S_IDLE : S_DATA;
            S_DATA:  if (bit_sample && bit_idx_q == 3'd7) state_d = S_STOP;
            S_STOP:  if (stop_sample) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_clr     = 1'b0;
        bit_sample  = 1'b0;
        stop_sample = 1'b0;
        case (state_q)
            S_IDLE:  cnt_clr = 1'b1;
            S_START: cnt_clr = (cnt_q == HALF_LAST);
            S_DATA: begin
                cnt_clr    = (cnt_q == BIT_LAST);
                bit_sample = (cnt_q == BIT_LAST);
            end
            S_STOP: begin
                cnt_clr     = (cnt_q == BIT_LAST);
                stop_sample = (cnt_q == BIT_LAST);
            end
            default: cnt_clr = 1'b1;
        endcase
    end

    assign byte_ok   = stop_sample && rx;
    assign frame_err = stop_sample && !rx;
    assign word_done = byte_ok && (byte_cnt_q == 2'd3);
    assign idle_wait = (state_q == S_IDLE) && (byte_cnt_q != 2'd0);
    assign timeout   = idle_wait && (idle_cnt_q == IDLE_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            cnt_q <= cnt_clr ? '0 : cnt_q + CNT_W'(1);
            if (state_q == S_IDLE) bit_idx_q <= '0;
            else if (bit_sample)   bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_sample) shift_q <= {rx, shift_q[7:1]};
        end
    end

    // setAddr takes priority over byte packing, word completion and timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_cnt_q <= '0;
            idle_cnt_q <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            last_q     <= '0;
        end else begin
            we_q <= word_done && !setAddr;
            if (byte_ok) last_q <= shift_q;

            if (setAddr)        addr_q <= startAddr;
            else if (we_q)      addr_q <= addr_q + 12'd1;

            if (setAddr)        err_q <= 1'b0;
            else if (frame_err) err_q <= 1'b1;

            if (byte_ok && !setAddr) data_q[{byte_cnt_q, 3'b000} +: 8] <= shift_q;

            if (setAddr || timeout) byte_cnt_q <= '0;
            else if (byte_ok)       byte_cnt_q <= byte_cnt_q + 2'd1;

            if (idle_wait && !timeout && !setAddr) idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
            else                                   idle_cnt_q <= '0;
        end
    end

    assign writeAddr   = addr_q;
    assign writeData   = data_q;
    assign writeEnable = we_q;
    assign err         = err_q;
    assign lastByte    = last_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_mem_loader.sv
// ============================================================================
// tb_uart_mem_loader : self-checking bench for uart_mem_loader (8 clks/bit).
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_uart_mem_loader;
    localparam int CPB  = 8;
    localparam int IDLE = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        serialIn = 1'b1;
    logic        setAddr = 1'b0;
    logic [11:0] startAddr = '0;
    logic [11:0] writeAddr;
    logic [31:0] writeData;
    logic        writeEnable;
    logic        err;
    logic [7:0]  lastByte;

    int tests = 0;
    int fails = 0;
    logic [7:0] last_good = 8'h00;

    typedef struct {
        logic [11:0]     addr;
        logic [3:0][7:0] b;
        logic [31:0]     exp_data;
        logic [11:0]     exp_next;
    } vec_t;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t  exp_q[$];
    vec_t vecs[3];

    uart_mem_loader #(.CLKS_PER_BIT(CPB), .IDLE_TIMEOUT(IDLE)) dut (
        .clk(clk), .reset(reset), .serialIn(serialIn),
        .setAddr(setAddr), .startAddr(startAddr),
        .writeAddr(writeAddr), .writeData(writeData),
        .writeEnable(writeEnable), .err(err), .lastByte(lastByte)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every observed write must match the oldest expected one.
    always @(negedge clk) begin
        if (!reset && writeEnable === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", writeAddr, writeData);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check("write_addr", {20'd0, writeAddr}, {20'd0, w.addr});
                check("write_data", writeData, w.data);
            end
        end
    end

    task automatic expect_write(input logic [11:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
        serialIn = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            serialIn = b[i];
            repeat (CPB) @(negedge clk);
        end
        serialIn = stop_bit;
        repeat (CPB) @(negedge clk);
        serialIn = 1'b1;
        if (stop_bit) last_good = b;
    endtask

    task automatic pulse_set(input logic [11:0] a);
        startAddr = a;
        setAddr   = 1'b1;
        @(negedge clk);
        setAddr   = 1'b0;
    endtask

    task automatic send_word(input logic [3:0][7:0] b);
        for (int i = 0; i < 4; i++) send_byte(b[i]);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{12'h010, {8'h08, 8'h20, 8'h00, 8'h13}, 32'h08200013, 12'h011};
        vecs[1] = '{12'h7A5, {8'h00, 8'hFF, 8'h5A, 8'hA5}, 32'h00FF5AA5, 12'h7A6};
        vecs[2] = '{12'h000, {8'hEF, 8'hBE, 8'hAD, 8'hDE}, 32'hEFBEADDE, 12'h001};

        repeat (3) @(negedge clk);
        check("reset_addr", {20'd0, writeAddr}, 32'd0);
        check("reset_data", writeData, 32'd0);
        check("reset_we", {31'd0, writeEnable}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        check("reset_last", {24'd0, lastByte}, 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        foreach (vecs[i]) begin
            pulse_set(vecs[i].addr);
            check("set_addr", {20'd0, writeAddr}, {20'd0, vecs[i].addr});
            expect_write(vecs[i].addr, vecs[i].exp_data);
            send_word(vecs[i].b);
            check("next_addr", {20'd0, writeAddr}, {20'd0, vecs[i].exp_next});
            check("last_byte", {24'd0, lastByte}, {24'd0, vecs[i].b[3]});
            check("no_err", {31'd0, err}, 32'd0);
        end

        // Address wrap 0xFFF -> 0x000.
        pulse_set(12'hFFF);
        expect_write(12'hFFF, 32'h04030201);
        expect_write(12'h000, 32'h08070605);
        send_word({8'h04, 8'h03, 8'h02, 8'h01});
        send_word({8'h08, 8'h07, 8'h06, 8'h05});
        check("wrap_addr", {20'd0, writeAddr}, 32'h001);

        // Framing error: sticky err, lastByte kept, partial word untouched.
        pulse_set(12'h100);
        send_byte(8'hAA, 1'b0);
        repeat (CPB) @(negedge clk);
        check("frame_err", {31'd0, err}, 32'd1);
        check("frame_last", {24'd0, lastByte}, 32'h08);
        expect_write(12'h100, 32'h99887766);
        send_word({8'h99, 8'h88, 8'h77, 8'h66});
        check("err_sticky", {31'd0, err}, 32'd1);
        pulse_set(12'h200);
        check("err_cleared", {31'd0, err}, 32'd0);

        // Idle timeout discards a partial word.
        send_byte(8'hEE);
        send_byte(8'hFF);
        repeat (IDLE * CPB + 1) @(negedge clk);
        check("timeout_addr", {20'd0, writeAddr}, 32'h200);
        expect_write(12'h200, 32'h44332211);
        send_word({8'h44, 8'h33, 8'h22, 8'h11});

        // Short low glitch is rejected without error or byte.
        serialIn = 1'b0;
        repeat (3) @(negedge clk);
        serialIn = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_err", {31'd0, err}, 32'd0);
        check("glitch_last", {24'd0, lastByte}, 32'h44);
        expect_write(12'h201, 32'hD4C3B2A1);
        send_word({8'hD4, 8'hC3, 8'hB2, 8'hA1});

        // setAddr on the stop-sample edge of the 4th byte wins.
        pulse_set(12'h400);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        fork
            send_byte(8'h04);
            begin
                repeat (78) @(negedge clk);
                pulse_set(12'h555);
            end
        join
        repeat (4) @(negedge clk);
        check("collide_addr", {20'd0, writeAddr}, 32'h555);
        expect_write(12'h555, 32'h0D0C0B0A);
        send_word({8'h0D, 8'h0C, 8'h0B, 8'h0A});

        // setAddr mid-byte: that byte becomes byte 0 of the new word.
        fork
            send_byte(8'h5A);
            begin
                repeat (30) @(negedge clk);
                pulse_set(12'h0A0);
            end
        join
        expect_write(12'h0A0, 32'hC3B2A15A);
        send_byte(8'hA1);
        send_byte(8'hB2);
        send_byte(8'hC3);
        repeat (4) @(negedge clk);
        check("midbyte_addr", {20'd0, writeAddr}, 32'h0A1);

        // Reset during bit 5 of the 4th byte aborts the word.
        pulse_set(12'h300);
        send_byte(8'h31);
        send_byte(8'h32);
        send_byte(8'h33);
        serialIn = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            serialIn = i[0];
            repeat (CPB) @(negedge clk);
        end
        serialIn = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_addr", {20'd0, writeAddr}, 32'd0);
        check("rst_data", writeData, 32'd0);
        check("rst_we", {31'd0, writeEnable}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_last", {24'd0, lastByte}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        expect_write(12'h000, 32'h78563412);
        send_word({8'h78, 8'h56, 8'h34, 8'h12});
        check("post_rst_addr", {20'd0, writeAddr}, 32'h001);

        repeat (10) @(negedge clk);
        check("pending_writes", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
